// File: rtl/tx_pkt_adapter.sv
// -----------------------------------------------------------------------------
// tx_pkt_adapter
//
// Purpose:
//   Upstream feeder for the transmit enqueue stage. It converts a user-side
//   64-bit valid/ready packet stream with byte keeps into the MAC packet
//   interface (pkt_tx_data/val/sop/eop/mod).
//   - pkt_tx_full and tx_enable only gate the *start* of a packet. Once a
//     packet has begun, it always runs to completion.
//   - It keeps wrap-around packet and byte statistics.
//   - It flags malformed keep patterns by toggling a status bit.
//
// Ports:
//   clk_156m25          in   MAC transmit clock
//   reset_156m25_n      in   asynchronous active-low reset
//   s_data[63:0]        in   user data; byte 0 = bits [7:0], first on wire
//   s_keep[7:0]         in   byte valid mask; bit i qualifies byte i
//   s_last              in   final beat of packet
//   s_valid             in   beat present
//   s_ready             out  beat accepted when s_valid && s_ready at edge
//   tx_enable           in   permit start of new packets
//   pkt_tx_full         in   downstream almost-full; blocks new packet start
//   pkt_tx_data[63:0]   out  registered data
//   pkt_tx_val          out  registered beat valid
//   pkt_tx_sop          out  first beat of packet
//   pkt_tx_eop          out  last beat of packet
//   pkt_tx_mod[2:0]     out  valid bytes in eop beat mod 8 (0 = all 8)
//   stat_pkt_cnt        out  packets forwarded (counted at eop)
//   stat_byte_cnt       out  bytes forwarded
//   status_keep_err_tog out  toggles once per malformed beat
// -----------------------------------------------------------------------------
module tx_pkt_adapter #(
  parameter int CNT_W = 32
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic [63:0]       s_data,
  input  logic [7:0]        s_keep,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              tx_enable,
  input  logic              pkt_tx_full,
  output logic [63:0]       pkt_tx_data,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [2:0]        pkt_tx_mod,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic [CNT_W-1:0]  stat_byte_cnt,
  output logic              status_keep_err_tog
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             w_ready;
  logic             w_accept;
  logic             w_sop;
  logic [7:0]       w_prefix;
  logic [3:0]       w_run_len;
  logic [2:0]       w_mod;
  logic             w_keep_err;
  logic [3:0]       w_byte_inc;

  logic [63:0]      r_data;
  logic             r_val;
  logic             r_sop;
  logic             r_eop;
  logic [2:0]       r_mod;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_keep_err_tog;

  // ---------------------------------------------------------------------------
  // Keep decoding.
  // w_prefix[i] is set only when keep bits 0..i are all ones. The number of
  // set prefix bits is the length of the contiguous run starting at byte 0.
  // The keep is contiguous-from-bit-0 exactly when w_prefix equals s_keep.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_prefix
      assign w_prefix[gi] = &s_keep[gi:0];
    end
  endgenerate

  always_comb begin
    w_run_len = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_run_len = w_run_len + {3'd0, w_prefix[i]};
    end
  end

  // A run of 8 wraps to mod 0, which means "all bytes valid".
  assign w_mod = s_last ? w_run_len[2:0] : 3'd0;

  assign w_keep_err = s_last ? ((s_keep == 8'h00) || (w_prefix != s_keep))
                             : (s_keep != 8'hFF);

  // An empty or malformed last beat with mod 0 still counts as 8 bytes.
  assign w_byte_inc = (!s_last || (w_mod == 3'd0)) ? 4'd8 : {1'b0, w_mod};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and ready.
  // Ready depends only on state and the gates, never on s_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_sop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = tx_enable && !pkt_tx_full;
        w_sop   = 1'b1;
        if (s_valid && w_ready && !s_last) begin
          w_state_next = ST_PKT;
        end
      end
      ST_PKT: begin
        // A started packet always drains, whatever the downstream gates say.
        w_ready = 1'b1;
        if (s_valid && s_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign s_ready  = w_ready;
  assign w_accept = s_valid && w_ready;

  // ---------------------------------------------------------------------------
  // Output beat register and statistics.
  // Data holds its last value between beats; markers are cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      r_data         <= 64'd0;
      r_val          <= 1'b0;
      r_sop          <= 1'b0;
      r_eop          <= 1'b0;
      r_mod          <= 3'd0;
      r_pkt_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_keep_err_tog <= 1'b0;
    end else begin
      r_val <= w_accept;
      if (w_accept) begin
        r_data     <= s_data;
        r_sop      <= w_sop;
        r_eop      <= s_last;
        r_mod      <= w_mod;
        r_byte_cnt <= r_byte_cnt + {{(CNT_W-4){1'b0}}, w_byte_inc};
        if (s_last) begin
          r_pkt_cnt <= r_pkt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (w_keep_err) begin
          r_keep_err_tog <= ~r_keep_err_tog;
        end
      end else begin
        r_sop <= 1'b0;
        r_eop <= 1'b0;
        r_mod <= 3'd0;
      end
    end
  end

  assign pkt_tx_data         = r_data;
  assign pkt_tx_val          = r_val;
  assign pkt_tx_sop          = r_sop;
  assign pkt_tx_eop          = r_eop;
  assign pkt_tx_mod          = r_mod;
  assign stat_pkt_cnt        = r_pkt_cnt;
  assign stat_byte_cnt       = r_byte_cnt;
  assign status_keep_err_tog = r_keep_err_tog;

endmodule

// File: doc/tx_pkt_adapter.md
# tx_pkt_adapter

Upstream feeder for the transmit enqueue stage. Converts a user-side 64-bit valid/ready packet stream with byte keeps into the MAC packet interface (pkt_tx_data/val/sop/eop/mod). Honours pkt_tx_full only at packet boundaries: a packet in progress always completes, and a new packet is held off. Keeps packet and byte statistics and flags malformed keep patterns.

## Interface
- CNT_W, 32, width of statistics counters (wrap-around).
- clk_156m25  in  1  MAC transmit clock.
- reset_156m25_n  in  1  reset, asynchronous, active-low; clock clk_156m25.
- s_data  in  64  user data; byte 0 = bits [7:0], first on wire.
- s_keep  in  8  byte valid mask; bit i qualifies byte i.
- s_last  in  1  final beat of packet.
- s_valid  in  1  beat present.
- s_ready  out  1  beat accepted when s_valid && s_ready at clock edge.
- tx_enable  in  1  permit start of new packets.
- pkt_tx_full  in  1  downstream almost-full; blocks new packet start.
- pkt_tx_data  out  64  registered data.
- pkt_tx_val  out  1  registered beat valid.
- pkt_tx_sop  out  1  first beat of packet (qualified by val).
- pkt_tx_eop  out  1  last beat (qualified by val).
- pkt_tx_mod  out  3  valid bytes in eop beat mod 8; 0 = all 8.
- stat_pkt_cnt  out  CNT_W  packets forwarded (counted at eop).
- stat_byte_cnt  out  CNT_W  bytes forwarded.
- status_keep_err_tog  out  1  toggles once per malformed beat.

## Operation
- FSM states IDLE, PKT. Reset state IDLE.
- IDLE: s_ready = tx_enable && !pkt_tx_full. Accepted beat -> sop=1; if s_last also eop=1 and stay IDLE, else go PKT.
- PKT: s_ready = 1 regardless of pkt_tx_full and tx_enable. Accepted beat with s_last -> eop=1, go IDLE. Gaps (s_valid=0) pass through as pkt_tx_val=0, state unchanged.
- Output register: every cycle pkt_tx_val <= s_valid && s_ready; data/sop/eop/mod loaded on accept; sop/eop/mod forced 0 when not valid. Data may hold last value when not valid.
- Mod: on last beat, n = count of contiguous ones starting at s_keep[0]; mod = n[2:0] (0xFF -> 0, 0x01 -> 1, 0x7F -> 7). Non-last beats: mod = 0.
- Keep error (accepted beat): non-last beat with s_keep != 0xFF, or last beat whose keep is not contiguous from bit 0 or is 0x00. Beat still forwarded unchanged; mod per contiguous-ones rule (0x00 -> mod 0); status_keep_err_tog inverts once per errored beat.
- Statistics on accept: stat_byte_cnt += 8 for non-last beat, += (mod==0 ? 8 : mod) for last beat; stat_pkt_cnt += 1 on last beat. Both wrap modulo 2^CNT_W; no saturation.
- tx_enable deassert mid-packet: current packet completes; next start blocked.
- pkt_tx_full assert mid-packet: ignored until return to IDLE.

## Timing
- Latency: accepted beat appears on pkt_tx_* exactly 1 cycle after acceptance edge.
- s_ready combinational from state, tx_enable, pkt_tx_full; no s_valid dependence.
- Back-to-back packets: eop beat and next sop beat may be accepted on consecutive cycles if gate open.
- Counters update on the same edge that registers the output beat.
- Reset (async, any time incl. mid-packet): state IDLE; pkt_tx_val/sop/eop=0, pkt_tx_mod=0, pkt_tx_data=0, stat counters=0, status_keep_err_tog=0. Partial packet discarded; downstream sees no eop for it.

## Test plan
- Single-beat packet, keep 0x0F, last=1, gate open -> next cycle val=sop=eop=1, mod=4; pkt_cnt=1, byte_cnt=4.
- 3-beat packet keeps FF,FF,FF -> sop on beat 1, eop on beat 3, mod=0; byte_cnt=24; s_ready held 1 throughout.
- pkt_tx_full=1 in IDLE with s_valid=1 -> s_ready=0, no output; full raised after sop of 4-beat packet -> all 4 beats forwarded, following packet stalled until full=0.
- Mid-packet s_valid gaps of 2 cycles -> pkt_tx_val low for 2 cycles, no extra sop, single eop.
- Malformed: non-last keep 0x7F, then last keep 0x05 -> both forwarded, toggle flips twice, last mod=1.
- Async reset asserted mid-packet then released; new 2-beat packet -> outputs and counters 0 during reset; new packet starts with sop=1, pkt_cnt=1.
